mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
Initiator side of the data memory interface: the MEM-stage load/store sequencer of the PA-RISC PPU that drives the byte-addressed, big-endian data memory (A, DI, DO, Size, RW, E). Accepts one load/store request at a time from the pipeline over a valid/ready handshake. Checks alignment and range, then issues a single memory access with a one-cycle write-enable pulse. Returns load data, zero- or sign-extended, with a fault flag.

Parameters:
ADDR_LIMIT, 256, number of addressable bytes; any access touching a byte at or above this limit faults.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  pipeline presents a request
req_ready  output  1  unit can accept a request this cycle
req_rw  input  1  0 = load, 1 = store
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  extended load data; 0 for stores and faults
resp_fault  output  1  alignment, range or size fault; valid with resp_valid
mem_a  output  32  to memory A
mem_di  output  32  to memory DI
mem_do  input  32  from memory DO
mem_size  output  2  to memory Size
mem_rw  output  1  to memory RW
mem_e  output  1  to memory E

Behaviour:
- Reset values (synchronous, active-high):
  - state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0.
  - mem_a=0, mem_di=0, mem_size=00, mem_rw=0, mem_e=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1. On req_valid, latch all req_* fields.
  - Compute fault:
    - size=11;
    - halfword with addr[0]=1;
    - word with addr[1:0]!=00;
    - addr+bytes-1 >= ADDR_LIMIT, evaluated in 33-bit arithmetic so wrap-around cannot mask a fault.
  - Fault -> RESP with fault latched; no memory access.
  - No fault -> ACCESS.
- ACCESS (exactly one cycle):
  - req_ready=0. mem_a, mem_size, mem_rw and mem_di are driven from the latched request.
  - mem_e=1 only if store. mem_e is 0 in every other state.
  - Load: capture mem_do at the end of the cycle.
  - Extension:
    - byte uses mem_do[7:0];
    - halfword uses mem_do[15:0];
    - word is taken as is;
    - sign bit is bit 7 or bit 15 when req_signed=1; otherwise zero-fill.
  - Next state is RESP.
- RESP (exactly one cycle):
  - resp_valid=1, resp_rdata and resp_fault are held registered, req_ready=0.
  - Next state is IDLE; resp_valid returns to 0.
- Latency: accepted request -> resp_valid 2 cycles later (1 cycle for faults). Throughput is one request per 3 cycles (per 2 for faults).
- Idle memory bus: mem_rw=0 and mem_e=0 outside ACCESS, so memory only sees reads. mem_a and mem_size hold their last values.
- req_valid in ACCESS or RESP is ignored; the pipeline must hold the request until req_ready.
- Reset mid-operation:
  - Any state -> IDLE next cycle; no response is issued.
  - A store whose ACCESS cycle coincides with reset may already be committed to memory.
- Store data width: only the low 8/16 bits are meaningful for byte/halfword; mem_di is passed unmodified.

Decomposition:
- Shared package ppu_mem_pkg holds:
  - size encodings: SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10;
  - RW encodings: RW_READ=0, RW_WRITE=1;
  - the state enum.
- One natural sub-module: load_extender, combinational (data, size, signed -> 32-bit result). It is reused later by the register-file writeback path.

Test Plan:
- Word store then load: store addr=0x10, wdata=0xDEADBEEF, size=10; then load addr=0x10 -> mem_e high for exactly one cycle during store; memory bytes 0x10..0x13 = DE AD BE EF; load resp_rdata=0xDEADBEEF, fault=0, resp_valid 2 cycles after accept.
- Signed/unsigned byte: memory byte 0x20=0x80; load size=00 signed=1 -> 0xFFFFFF80; signed=0 -> 0x00000080.
- Halfword: bytes 0x30,0x31 = 0x12,0xF4; load size=01 signed=1 -> 0xFFFF12F4 is wrong, expect 0x000012F4; signed=1 with bytes 0xF4,0x12 -> 0xFFFFF412.
- Faults:
  - load half at 0x21 -> fault=1, rdata=0, response 1 cycle after accept, mem_e never asserted;
  - word at 0xFE -> fault;
  - word at 0xFC -> no fault;
  - addr 0xFFFFFFFC word -> fault (no wrap);
  - size=11 -> fault.
- Handshake: hold req_valid continuously with back-to-back loads -> accepts spaced 3 cycles apart; req_ready=0 in ACCESS/RESP; no duplicate responses.
- Reset mid-load in ACCESS -> next cycle IDLE, resp_valid never asserted, req_ready=1, all outputs at reset values.

Source files
------------

// File: rtl/ppu_mem_pkg.sv
// ppu_mem_pkg: shared encodings for the PPU data-memory interface.
//   - access size codes driven on Size
//   - read/write codes driven on RW
//   - sequencer state type for mem_access_unit
//   - size_bytes(): number of bytes touched by a given size code
package ppu_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } mau_state_e;

  // Illegal size reports one byte; it faults on the size check anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extender.sv
// load_extender: right-justified load data -> 32-bit register value.
//   data      in  32  raw memory read data (right-justified)
//   size      in  2   SIZE_BYTE / SIZE_HALF / SIZE_WORD
//   is_signed in  1   1 = sign-extend from bit 7/15, 0 = zero-fill
//   result    out 32  extended value
// Purely combinational; also used by the register-file writeback path.
module load_extender
  import ppu_mem_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  always_comb begin
    result = data;
    case (size)
      SIZE_BYTE: result = {{24{is_signed & data[7]}},  data[7:0]};
      SIZE_HALF: result = {{16{is_signed & data[15]}}, data[15:0]};
      default:   result = data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer driving the big-endian,
// byte-addressed data memory.
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake from the pipeline
//   req_rw/size/signed     access type, width, load extension mode
//   req_addr/req_wdata     byte address, right-justified store data
//   resp_valid             one-cycle response strobe
//   resp_rdata/resp_fault  extended load data (0 for stores/faults), fault flag
//   mem_a/di/size/rw/e     memory address, write data, size, direction, enable
//   mem_do                 memory read data
// Flow: IDLE (accept + check) -> ACCESS (one cycle on the bus) -> RESP,
// or IDLE -> RESP directly when the request faults.
module mem_access_unit
  import ppu_mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_a,
  output logic [31:0] mem_di,
  input  logic [31:0] mem_do,
  output logic [1:0]  mem_size,
  output logic        mem_rw,
  output logic        mem_e
);

  mau_state_e  state_q, state_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [31:0] mem_di_q, mem_di_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_e_q, mem_e_d;
  logic        signed_q, signed_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_fault_q, resp_fault_d;

  logic [32:0] last_byte;
  logic        size_fault, align_fault, range_fault, req_fault;
  logic [31:0] ext_data;

  // Last byte touched, in 33 bits so an address near 2^32 cannot wrap
  // back under the limit.
  always_comb begin
    last_byte   = {1'b0, req_addr} + 33'(size_bytes(req_size)) - 33'd1;
    size_fault  = (req_size == SIZE_ILL);
    align_fault = ((req_size == SIZE_HALF) && req_addr[0]) ||
                  ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    range_fault = (last_byte >= 33'(ADDR_LIMIT));
    req_fault   = size_fault | align_fault | range_fault;
  end

  load_extender u_load_extender (
    .data      (mem_do),
    .size      (mem_size_q),
    .is_signed (signed_q),
    .result    (ext_data)
  );

  // Bus outputs are registered: they are loaded on the accepting edge so
  // they are stable for the whole ACCESS cycle, and rw/e drop on leaving it.
  always_comb begin
    state_d      = state_q;
    mem_a_d      = mem_a_q;
    mem_di_d     = mem_di_q;
    mem_size_d   = mem_size_q;
    mem_rw_d     = RW_READ;
    mem_e_d      = 1'b0;
    signed_d     = signed_q;
    resp_rdata_d = resp_rdata_q;
    resp_fault_d = resp_fault_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          signed_d = req_signed;
          if (req_fault) begin
            state_d      = ST_RESP;
            resp_fault_d = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d    = ST_ACCESS;
            mem_a_d    = req_addr;
            mem_di_d   = req_wdata;
            mem_size_d = req_size;
            mem_rw_d   = req_rw;
            mem_e_d    = (req_rw == RW_WRITE);
          end
        end
      end
      ST_ACCESS: begin
        state_d      = ST_RESP;
        resp_fault_d = 1'b0;
        resp_rdata_d = (mem_rw_q == RW_WRITE) ? '0 : ext_data;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mem_a_q      <= '0;
      mem_di_q     <= '0;
      mem_size_q   <= SIZE_BYTE;
      mem_rw_q     <= RW_READ;
      mem_e_q      <= 1'b0;
      signed_q     <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_a_q      <= mem_a_d;
      mem_di_q     <= mem_di_d;
      mem_size_q   <= mem_size_d;
      mem_rw_q     <= mem_rw_d;
      mem_e_q      <= mem_e_d;
      signed_q     <= signed_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;
  assign mem_a      = mem_a_q;
  assign mem_di     = mem_di_q;
  assign mem_size   = mem_size_q;
  assign mem_rw     = mem_rw_q;
  assign mem_e      = mem_e_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed + randomized load/store traffic against a
// byte-array reference of the 256-byte big-endian memory.
module tb_mem_access_unit;
  import ppu_mem_pkg::*;

  localparam int LIMIT = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_rw, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_di, mem_do;
  logic [1:0]  mem_size;
  logic        mem_rw, mem_e;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault), .mem_a(mem_a), .mem_di(mem_di), .mem_do(mem_do),
    .mem_size(mem_size), .mem_rw(mem_rw), .mem_e(mem_e)
  );

  // Bench memory: big-endian, right-justified read data with junk in the
  // unused upper bits so the extender must ignore them.
  logic [7:0] a0, a1, a2, a3;
  assign a0 = mem_a[7:0];
  assign a1 = mem_a[7:0] + 8'd1;
  assign a2 = mem_a[7:0] + 8'd2;
  assign a3 = mem_a[7:0] + 8'd3;

  always_comb begin
    mem_do = '0;
    case (mem_size)
      2'b00:   mem_do = {24'hC3A55A, mem[a0]};
      2'b01:   mem_do = {16'h5AC3, mem[a0], mem[a1]};
      default: mem_do = {mem[a0], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_e && mem_rw) begin
      case (mem_size)
        2'b00: mem[a0] <= mem_di[7:0];
        2'b01: begin mem[a0] <= mem_di[15:8]; mem[a1] <= mem_di[7:0]; end
        default: begin
          mem[a0] <= mem_di[31:24]; mem[a1] <= mem_di[23:16];
          mem[a2] <= mem_di[15:8];  mem[a3] <= mem_di[7:0];
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_fault(input logic [1:0] sz, input logic [31:0] addr);
    longint a;
    a = longint'({32'b0, addr});
    if (sz == 2'b11) return 1'b1;
    if ((a % nbytes(sz)) != 0) return 1'b1;
    if (a + nbytes(sz) > LIMIT) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] addr);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[int'(addr) + i]);
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd);
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = 8'(wd >> (8 * (n - 1 - i)));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_rvalid"}, 32'(resp_valid), 32'd0);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_fault"}, 32'(resp_fault), 32'd0);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_di"}, mem_di, 32'd0);
    check({tag, "_mem_ctl"}, {29'd0, mem_size, mem_rw}, 32'd0);
    check({tag, "_mem_e"}, 32'(mem_e), 32'd0);
  endtask

  // One full transaction: drive, wait for accept, observe 4 cycles after.
  task automatic do_req(input logic rw, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          f_e;
    logic [31:0] rd_e;
    int          wait_c, lat, ecnt, vcnt, exp_lat;
    logic [31:0] rd_got;
    logic        flt_got, busy_ok;
    f_e  = model_fault(sz, addr);
    rd_e = '0;
    if (!f_e && !rw) rd_e = model_load(sz, sg, addr);
    if (!f_e && rw)  model_store(sz, addr, wd);
    exp_lat = f_e ? 1 : 2;

    @(negedge clk);
    req_rw = rw; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    wait_c = 0;
    while (!req_ready && wait_c < 10) begin @(negedge clk); wait_c++; end
    check("accept_wait", 32'(wait_c < 10), 32'd1);

    lat = -1; ecnt = 0; vcnt = 0; busy_ok = 1'b1; rd_got = 'x; flt_got = 1'bx;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      if (mem_e) ecnt++;
      if (resp_valid) begin
        vcnt++;
        if (lat < 0) begin lat = k; rd_got = resp_rdata; flt_got = resp_fault; end
      end
      if (k <= exp_lat && req_ready) busy_ok = 1'b0;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_count", 32'(vcnt), 32'd1);
    check("mem_e_cycles", 32'(ecnt), (rw && !f_e) ? 32'd1 : 32'd0);
    check("rdata", rd_got, rd_e);
    check("fault", 32'(flt_got), 32'(f_e));
    check("busy_ready_low", 32'(busy_ok), 32'd1);
  endtask

  initial begin
    int          acc[$];
    int          rsp, diffs, mode;
    logic [31:0] w, ra;
    logic [1:0]  rs;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // word store then load
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    w = {mem[16], mem[17], mem[18], mem[19]};
    check("store_bytes", w, 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    // byte sign/zero extension
    do_req(1'b1, 2'b00, 1'b0, 32'h20, 32'h0000_0080);
    do_req(1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);

    // halfword extension
    do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'hABCD_12F4);
    do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000_F412);
    do_req(1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
    do_req(1'b0, 2'b01, 1'b0, 32'h30, 32'h0);

    // faults and range boundaries
    do_req(1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFE, 32'h0);
    do_req(1'b0, 2'b10, 1'b0, 32'hFC, 32'h0);
    do_req(1'b1, 2'b10, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678);
    do_req(1'b1, 2'b11, 1'b0, 32'h40, 32'h1111_1111);
    do_req(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0);
    do_req(1'b0, 2'b00, 1'b0, 32'h100, 32'h0);

    // back-to-back: request held valid continuously
    @(negedge clk);
    req_rw = 1'b0; req_size = 2'b00; req_signed = 1'b1; req_addr = 32'h20;
    req_valid = 1'b1;
    rsp = 0;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc.push_back(c);
      if (resp_valid) begin
        rsp++;
        check("b2b_rdata", resp_rdata, 32'hFFFF_FF80);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_accepts", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++) check("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    check("b2b_responses", 32'(rsp), 32'd4);
    repeat (3) @(negedge clk);

    // reset during the ACCESS cycle of a load
    req_rw = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_rst_busy", 32'(req_ready), 32'd0);
    check("mid_rst_mem_a", mem_a, 32'h10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("mid_rst");
    rsp = 0;
    for (int c = 0; c < 4; c++) begin
      if (resp_valid) rsp++;
      @(negedge clk);
    end
    check("mid_rst_no_resp", 32'(rsp), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      mode = $urandom_range(0, 9);
      if (mode < 7)      ra = 32'($urandom_range(0, 259));
      else if (mode < 9) ra = 32'($urandom_range(0, 63) * 4);
      else               ra = $urandom;
      rs = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom);
    end

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("mem_image", 32'(diffs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
